// File: rtl/aes_v3_pkg.sv
// Shared types and GF(2^8) helpers for the sequential AES v3 unit.
package aes_v3_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [7:0] ENC_M3 = 8'd3;
  localparam logic [7:0] ENC_M2 = 8'd1;
  localparam logic [7:0] ENC_M1 = 8'd1;
  localparam logic [7:0] ENC_M0 = 8'd2;
  localparam logic [7:0] DEC_M3 = 8'd11;
  localparam logic [7:0] DEC_M2 = 8'd13;
  localparam logic [7:0] DEC_M1 = 8'd9;
  localparam logic [7:0] DEC_M0 = 8'd14;

  function automatic logic [7:0] xtime2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply, modulus 0x11b.
  function automatic logic [7:0] xtime_n(input logic [7:0] a, input logic [7:0] n);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (n[i]) p = p ^ x;
      x = xtime2(x);
    end
    return p;
  endfunction

  // Column contribution of one byte, msb byte first.
  function automatic logic [31:0] mix_term(input logic [7:0] a, input logic dec);
    if (dec)
      return {xtime_n(a, DEC_M3), xtime_n(a, DEC_M2), xtime_n(a, DEC_M1), xtime_n(a, DEC_M0)};
    return {xtime_n(a, ENC_M3), xtime_n(a, ENC_M2), xtime_n(a, ENC_M1), xtime_n(a, ENC_M0)};
  endfunction

  function automatic logic [31:0] rot_bytes(input logic [31:0] w, input logic [1:0] r);
    case (r)
      2'd0:    return w;
      2'd1:    return {w[23:0], w[31:24]};
      2'd2:    return {w[15:0], w[31:16]};
      default: return {w[7:0], w[31:8]};
    endcase
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward/inverse S-box computed as GF(2^8) inversion plus affine map.
module aes_sbox
  import aes_v3_pkg::*;
(
  input  logic [7:0] a,
  input  logic       dec,
  output logic [7:0] y
);

  // a^254 is the multiplicative inverse, with 0 mapping to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] v);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h01;
    x = v;
    for (int k = 1; k < 8; k++) begin
      x = xtime_n(x, x);
      p = xtime_n(p, x);
    end
    return p;
  endfunction

  logic [7:0] pre;
  logic [7:0] inv;

  always_comb begin
    pre = a;
    if (dec) pre = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    inv = gf_inv(pre);
    y   = inv;
    if (!dec) y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_v3_lane.sv
// One byte lane: S-box result and 32-bit column term; unused path sees zero.
module aes_v3_lane
  import aes_v3_pkg::*;
(
  input  logic [7:0]  a,
  input  logic        dec,
  input  logic        mix,
  output logic [7:0]  sub,
  output logic [31:0] term
);

  logic [7:0] sbox_in;

  assign sbox_in = mix ? 8'h00 : a;
  assign term    = mix_term(mix ? a : 8'h00, dec);

  aes_sbox u_sbox (
    .a   (sbox_in),
    .dec (dec),
    .y   (sub)
  );

endmodule

// File: rtl/aes_v3_seq_unit.sv
// Multi-cycle SubBytes/MixColumn ^ rs2 unit with NLANE shared byte lanes.
// Define AES_V3_SEQ_FAST_MIX_EN to finish MixColumn ops in a single BUSY cycle.
module aes_v3_seq_unit
  import aes_v3_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NLANE = 1
) (
  input  logic            g_clk,
  input  logic            g_rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_dec,
  input  logic            in_mix,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rd
);

  localparam int unsigned NBYTE = XLEN / 8;
  localparam int unsigned NSTEP = NBYTE / NLANE;
  localparam int unsigned SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  state_t          state_q, state_d;
  logic [SW-1:0]   step_q, step_d;
  logic            dec_q, dec_d, mix_q, mix_d;
  logic [XLEN-1:0] rs1_q, rs1_d, acc_q, acc_d, rd_d, acc_step;
  logic            lane_en;

  logic [7:0]  lane_a    [NLANE];
  logic [7:0]  lane_sub  [NLANE];
  logic [31:0] lane_term [NLANE];

`ifdef AES_V3_SEQ_FAST_MIX_EN
  assign lane_en = (state_q == BUSY) && !mix_q;
`else
  assign lane_en = (state_q == BUSY);
`endif

  always_comb begin
    for (int l = 0; l < int'(NLANE); l++) begin
      lane_a[l] = 8'h00;
      if (lane_en) lane_a[l] = rs1_q[8*(int'(step_q)*int'(NLANE) + l) +: 8];
    end
  end

  for (genvar g = 0; g < int'(NLANE); g++) begin : g_lane
    aes_v3_lane u_lane (
      .a    (lane_a[g]),
      .dec  (dec_q),
      .mix  (mix_q),
      .sub  (lane_sub[g]),
      .term (lane_term[g])
    );
  end

  // Fold this step's lane results into the accumulator.
  always_comb begin
    acc_step = acc_q;
    for (int l = 0; l < int'(NLANE); l++) begin
      int idx;
      idx = int'(step_q) * int'(NLANE) + l;
      if (mix_q)
        acc_step[32*(idx/4) +: 32] = acc_step[32*(idx/4) +: 32] ^ rot_bytes(lane_term[l], 2'(idx % 4));
      else
        acc_step[8*idx +: 8] = acc_step[8*idx +: 8] ^ lane_sub[l];
    end
  end

`ifdef AES_V3_SEQ_FAST_MIX_EN
  logic [XLEN-1:0] acc_fast;

  always_comb begin
    acc_fast = acc_q;
    for (int i = 0; i < int'(NBYTE); i++)
      acc_fast[32*(i/4) +: 32] = acc_fast[32*(i/4) +: 32]
        ^ rot_bytes(mix_term((state_q == BUSY && mix_q) ? rs1_q[8*i +: 8] : 8'h00, dec_q), 2'(i % 4));
  end
`endif

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    dec_d   = dec_q;
    mix_d   = mix_q;
    rs1_d   = rs1_q;
    acc_d   = acc_q;
    rd_d    = out_rd;
    case (state_q)
      IDLE: begin
        if (!flush && in_valid && in_ready) begin
          state_d = BUSY;
          step_d  = '0;
          dec_d   = in_dec;
          mix_d   = in_mix;
          rs1_d   = in_rs1;
          acc_d   = in_rs2;
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
          step_d  = '0;
          acc_d   = '0;
`ifdef AES_V3_SEQ_FAST_MIX_EN
        end else if (mix_q) begin
          state_d = DONE;
          step_d  = '0;
          acc_d   = acc_fast;
          rd_d    = acc_fast;
`endif
        end else if (step_q == SW'(NSTEP - 1)) begin
          state_d = DONE;
          step_d  = '0;
          acc_d   = acc_step;
          rd_d    = acc_step;
        end else begin
          step_d = step_q + SW'(1);
          acc_d  = acc_step;
        end
      end
      DONE: begin
        if (flush) begin
          state_d = IDLE;
          acc_d   = '0;
        end else if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) begin
      state_q   <= IDLE;
      step_q    <= '0;
      dec_q     <= 1'b0;
      mix_q     <= 1'b0;
      rs1_q     <= '0;
      acc_q     <= '0;
      out_rd    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      dec_q     <= dec_d;
      mix_q     <= mix_d;
      rs1_q     <= rs1_d;
      acc_q     <= acc_d;
      out_rd    <= rd_d;
      out_valid <= (state_d == DONE);
      in_ready  <= (state_d == IDLE);
    end
  end

endmodule

// File: tb/tb_aes_v3_seq_unit.sv
// Scoreboard bench: 32-bit/1-lane and 64-bit/2-lane instances driven with directed vectors.
module tb_aes_v3_seq_unit;

  typedef struct {
    logic [63:0] rd;
    int          acc_cyc;
    int          lat;
  } exp_t;

`ifdef AES_V3_SEQ_FAST_MIX_EN
  localparam int MIX_LAT = 1;
`else
  localparam int MIX_LAT = 4;
`endif
  localparam int SUB_LAT = 4;

  logic        g_clk = 1'b0;
  logic        g_rst;
  logic        iv32, rdy32, dec32, mix32, fl32, ov32, or32;
  logic [31:0] rs1_32, rs2_32, rd32;
  logic        iv64, rdy64, dec64, mix64, fl64, ov64, or64;
  logic [63:0] rs1_64, rs2_64, rd64;

  int   cyc = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  exp_t q32[$];
  exp_t q64[$];
  logic pv32 = 1'b0;
  logic pv64 = 1'b0;

  always #5 g_clk = ~g_clk;
  always @(posedge g_clk) cyc <= cyc + 1;

  aes_v3_seq_unit #(.XLEN(32), .NLANE(1)) u_d32 (
    .g_clk(g_clk), .g_rst(g_rst), .in_valid(iv32), .in_ready(rdy32), .in_dec(dec32),
    .in_mix(mix32), .in_rs1(rs1_32), .in_rs2(rs2_32), .flush(fl32), .out_valid(ov32),
    .out_ready(or32), .out_rd(rd32));

  aes_v3_seq_unit #(.XLEN(64), .NLANE(2)) u_d64 (
    .g_clk(g_clk), .g_rst(g_rst), .in_valid(iv64), .in_ready(rdy64), .in_dec(dec64),
    .in_mix(mix64), .in_rs1(rs1_64), .in_rs2(rs2_64), .flush(fl64), .out_valid(ov64),
    .out_ready(or64), .out_rd(rd64));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    chk_cnt++;
    if (act === want) pass_cnt++;
    else $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, want, $time);
  endtask

  task automatic fail_bound(input string name);
    chk_cnt++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Monitors: every valid cycle must show the head expectation; pop on handshake.
  always @(negedge g_clk) begin
    if (ov32 === 1'b1) begin
      if (q32.size() == 0) fail_bound("unexpected_valid32");
      else begin
        if (!pv32) check("lat32", 64'(cyc - q32[0].acc_cyc), 64'(q32[0].lat));
        check("rd32", 64'(rd32), q32[0].rd);
        if (or32) q32.delete(0);
      end
    end
    pv32 <= ov32;
  end

  always @(negedge g_clk) begin
    if (ov64 === 1'b1) begin
      if (q64.size() == 0) fail_bound("unexpected_valid64");
      else begin
        if (!pv64) check("lat64", 64'(cyc - q64[0].acc_cyc), 64'(q64[0].lat));
        check("rd64", rd64, q64[0].rd);
        if (or64) q64.delete(0);
      end
    end
    pv64 <= ov64;
  end

  // Called at posedge+1; returns at the accept edge +1.
  task automatic issue(input bit wide, input bit push, input logic dec, input logic mix,
                       input logic [63:0] rs1, input logic [63:0] rs2,
                       input logic [63:0] want, input int lat);
    int   n;
    exp_t e;
    n = 0;
    while (((wide ? rdy64 : rdy32) !== 1'b1) && n < 200) begin
      @(posedge g_clk); #1;
      n++;
    end
    if (n >= 200) fail_bound("ready_timeout");
    e.rd = want;
    e.acc_cyc = cyc + 1;
    e.lat = lat;
    if (wide) begin
      iv64 = 1'b1; dec64 = dec; mix64 = mix; rs1_64 = rs1; rs2_64 = rs2;
      if (push) q64.push_back(e);
    end else begin
      iv32 = 1'b1; dec32 = dec; mix32 = mix; rs1_32 = rs1[31:0]; rs2_32 = rs2[31:0];
      if (push) q32.push_back(e);
    end
    @(posedge g_clk); #1;
    iv32 = 1'b0;
    iv64 = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!(q32.size() == 0 && q64.size() == 0 && rdy32 === 1'b1 && rdy64 === 1'b1) && n < 300) begin
      @(posedge g_clk); #1;
      n++;
    end
    if (n >= 300) fail_bound("drain");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    g_rst = 1'b1;
    iv32 = 0; dec32 = 0; mix32 = 0; rs1_32 = '0; rs2_32 = '0; fl32 = 0; or32 = 1;
    iv64 = 0; dec64 = 0; mix64 = 0; rs1_64 = '0; rs2_64 = '0; fl64 = 0; or64 = 1;
    repeat (2) @(posedge g_clk);
    #1;
    check("rst_valid32", 64'(ov32), 64'd0);
    check("rst_rd32", 64'(rd32), 64'd0);
    check("rst_ready32", 64'(rdy32), 64'd0);
    check("rst_rd64", rd64, 64'd0);
    g_rst = 1'b0;
    @(posedge g_clk); #1;
    check("post_rst_ready32", 64'(rdy32), 64'd1);
    check("post_rst_ready64", 64'(rdy64), 64'd1);

    // Main function vectors.
    issue(1, 1, 0, 1, 64'h455313DB_455313DB, 64'h00000000_FFFFFFFF, 64'hBCA14D8E_435EB271, MIX_LAT);
    issue(0, 1, 0, 0, 64'h0, 64'h0, 64'h63636363, SUB_LAT);
    issue(1, 1, 0, 0, 64'h0, 64'h0, 64'h63636363_63636363, SUB_LAT);
    issue(0, 1, 1, 0, 64'h63636363, 64'hFFFFFFFF, 64'hFFFFFFFF, SUB_LAT);
    issue(0, 1, 0, 0, 64'h01020304, 64'h0, 64'h7C777BF2, SUB_LAT);
    issue(0, 1, 1, 0, 64'h7C777BF2, 64'h0, 64'h01020304, SUB_LAT);
    issue(0, 1, 0, 1, 64'h455313DB, 64'h0, 64'hBCA14D8E, MIX_LAT);
    issue(0, 1, 1, 1, 64'hBCA14D8E, 64'h0, 64'h455313DB, MIX_LAT);
    issue(0, 1, 0, 1, 64'h01010101, 64'h12345678, 64'h13355779, MIX_LAT);
    drain();

    // Backpressure: hold out_ready low for 10 cycles.
    or32 = 1'b0;
    issue(0, 1, 0, 0, 64'h0, 64'h0, 64'h63636363, SUB_LAT);
    n = 0;
    while (ov32 !== 1'b1 && n < 20) begin
      @(posedge g_clk); #1;
      n++;
    end
    if (n >= 20) fail_bound("bp_valid");
    for (int k = 0; k < 10; k++) begin
      @(posedge g_clk); #1;
      check("bp_ready_low", 64'(rdy32), 64'd0);
      check("bp_valid_held", 64'(ov32), 64'd1);
    end
    or32 = 1'b1;
    @(posedge g_clk); #1;
    or32 = 1'b0;
    check("bp_ready_after", 64'(rdy32), 64'd1);
    check("bp_valid_after", 64'(ov32), 64'd0);
    or32 = 1'b1;

    // Flush in IDLE must suppress the same-cycle accept.
    iv32 = 1'b1; fl32 = 1'b1; rs1_32 = '0; rs2_32 = '0; mix32 = 0; dec32 = 0;
    @(posedge g_clk); #1;
    iv32 = 1'b0; fl32 = 1'b0;
    check("flush_idle_ready", 64'(rdy32), 64'd1);

    // Flush at step 2 drops the op.
    issue(0, 0, 0, 0, 64'hDEADBEEF, 64'h0, 64'h0, SUB_LAT);
    @(posedge g_clk); #1;
    @(posedge g_clk); #1;
    fl32 = 1'b1;
    @(posedge g_clk); #1;
    fl32 = 1'b0;
    check("flush_valid", 64'(ov32), 64'd0);
    check("flush_ready", 64'(rdy32), 64'd1);
    repeat (6) @(posedge g_clk);
    #1;
    issue(0, 1, 0, 0, 64'h0, 64'h0, 64'h63636363, SUB_LAT);
    drain();

    // Reset mid-op.
    issue(0, 0, 0, 0, 64'hDEADBEEF, 64'h0, 64'h0, SUB_LAT);
    @(posedge g_clk); #1;
    @(posedge g_clk); #1;
    g_rst = 1'b1;
    #2;
    check("midrst_valid32", 64'(ov32), 64'd0);
    check("midrst_rd32", 64'(rd32), 64'd0);
    check("midrst_ready32", 64'(rdy32), 64'd0);
    check("midrst_rd64", rd64, 64'd0);
    @(posedge g_clk); #1;
    g_rst = 1'b0;
    @(posedge g_clk); #1;
    check("midrst_ready_after32", 64'(rdy32), 64'd1);
    check("midrst_ready_after64", 64'(rdy64), 64'd1);
    repeat (6) @(posedge g_clk);
    #1;
    issue(0, 1, 0, 0, 64'h0, 64'h0, 64'h63636363, SUB_LAT);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
